multi_input_conditioner: RTL and testbench

Parametrised, multi-channel successor to the single-channel input conditioner. Each of CHANNELS asynchronous, noisy inputs (buttons, switches, external pins) is synchronised through a configurable flop chain and debounced with a per-channel stability counter. Each channel produces a clean level plus one-cycle rising and falling edge pulses. New in this generation: sticky per-channel event flags with a clear handshake, so slow consumers (FSMs, a polling CPU) cannot miss an edge. The block sits between top-level pins and all downstream logic.

---
 rtl/multi_input_conditioner.sv | 91 +++++++++
 tb/tb_multi_input_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multi_input_conditioner.sv
// Multi-channel input conditioner: per-channel synchroniser and debouncer with
// registered edge pulses, sticky edge flags with a clear handshake, and an OR of all flags.
module multi_input_conditioner #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int WAITTIME    = 3,
   parameter int COUNTWIDTH  = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] noisysignal,
   output logic [CHANNELS-1:0] conditioned,
   output logic [CHANNELS-1:0] positiveedge,
   output logic [CHANNELS-1:0] negativeedge,
   output logic [CHANNELS-1:0] pendingrise,
   output logic [CHANNELS-1:0] pendingfall,
   input  logic [CHANNELS-1:0] clearpending,
   output logic                anypending
);

   localparam logic [COUNTWIDTH-1:0] LASTCOUNT = COUNTWIDTH'(WAITTIME - 1);

   logic [SYNC_STAGES-1:0] r_sync  [CHANNELS];
   logic [COUNTWIDTH-1:0]  r_count [CHANNELS];
   logic [CHANNELS-1:0]    r_conditioned;
   logic [CHANNELS-1:0]    r_positiveEdge;
   logic [CHANNELS-1:0]    r_negativeEdge;
   logic [CHANNELS-1:0]    r_pendingRise;
   logic [CHANNELS-1:0]    r_pendingFall;
   logic                   r_anyPending;

   logic [CHANNELS-1:0]    w_sync;
   logic [CHANNELS-1:0]    w_expired;
   logic [CHANNELS-1:0]    w_riseEvent;
   logic [CHANNELS-1:0]    w_fallEvent;
   logic [CHANNELS-1:0]    w_riseNext;
   logic [CHANNELS-1:0]    w_fallNext;

   // A channel commits its new level once the disagreement has lasted WAITTIME samples;
   // a simultaneous set beats clearpending, and the other flag of that channel still clears.
   always_comb begin
      w_sync    = '0;
      w_expired = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         w_sync[ch]    = r_sync[ch][SYNC_STAGES-1];
         w_expired[ch] = (w_sync[ch] != r_conditioned[ch]) && (r_count[ch] == LASTCOUNT);
      end
      w_riseEvent = w_expired & w_sync;
      w_fallEvent = w_expired & ~w_sync;
      w_riseNext  = w_riseEvent | (r_pendingRise & ~clearpending);
      w_fallNext  = w_fallEvent | (r_pendingFall & ~clearpending);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            r_sync[ch]  <= '0;
            r_count[ch] <= '0;
         end
         r_conditioned  <= '0;
         r_positiveEdge <= '0;
         r_negativeEdge <= '0;
         r_pendingRise  <= '0;
         r_pendingFall  <= '0;
         r_anyPending   <= 1'b0;
      end else begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], noisysignal[ch]};
            if ((w_sync[ch] == r_conditioned[ch]) || w_expired[ch]) begin
               r_count[ch] <= '0;
            end else begin
               r_count[ch] <= r_count[ch] + 1'b1;
            end
         end
         r_conditioned  <= r_conditioned ^ w_expired;
         r_positiveEdge <= w_riseEvent;
         r_negativeEdge <= w_fallEvent;
         r_pendingRise  <= w_riseNext;
         r_pendingFall  <= w_fallNext;
         r_anyPending   <= |(w_riseNext | w_fallNext);
      end
   end

   assign conditioned  = r_conditioned;
   assign positiveedge = r_positiveEdge;
   assign negativeedge = r_negativeEdge;
   assign pendingrise  = r_pendingRise;
   assign pendingfall  = r_pendingFall;
   assign anypending   = r_anyPending;

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Directed self-checking bench for multi_input_conditioner at default parameters,
// 20 ns clock; inputs change and outputs are sampled 1 ns after each rising edge.
module tb_multi_input_conditioner;

   logic       clk;
   logic       reset;
   logic [3:0] noisysignal;
   logic [3:0] clearpending;
   logic [3:0] conditioned;
   logic [3:0] positiveedge;
   logic [3:0] negativeedge;
   logic [3:0] pendingrise;
   logic [3:0] pendingfall;
   logic       anypending;

   int compareCount  = 0;
   int mismatchCount = 0;

   multi_input_conditioner #(
      .CHANNELS(4), .SYNC_STAGES(2), .WAITTIME(3), .COUNTWIDTH(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .noisysignal(noisysignal),
      .conditioned(conditioned),
      .positiveedge(positiveedge),
      .negativeedge(negativeedge),
      .pendingrise(pendingrise),
      .pendingfall(pendingfall),
      .clearpending(clearpending),
      .anypending(anypending)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] noisy, input logic [3:0] clear);
      noisysignal  = noisy;
      clearpending = clear;
   endtask

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " conditioned"}, conditioned, 4'b0000);
      checkOutput({tag, " positiveedge"}, positiveedge, 4'b0000);
      checkOutput({tag, " negativeedge"}, negativeedge, 4'b0000);
      checkOutput({tag, " pendingrise"}, pendingrise, 4'b0000);
      checkOutput({tag, " pendingfall"}, pendingfall, 4'b0000);
      checkOutput({tag, " anypending"}, anypending, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(4'b1111, 4'b0000);

      $display("[TB] test 1: reset with all inputs high");
      repeat (2) stepEdge();
      checkAllZero("t1 in reset");
      reset = 1'b0;
      repeat (4) stepEdge();
      checkOutput("t1 cond edge4", conditioned, 4'b0000);
      stepEdge();
      checkOutput("t1 cond edge5", conditioned, 4'b1111);
      checkOutput("t1 posedge edge5", positiveedge, 4'b1111);
      checkOutput("t1 pendingrise", pendingrise, 4'b1111);
      checkOutput("t1 anypending", anypending, 1'b1);
      stepEdge();
      checkOutput("t1 posedge edge6", positiveedge, 4'b0000);

      applyStimulus(4'b0000, 4'b0000);
      reset = 1'b1;
      stepEdge();
      checkAllZero("t1 re-reset");
      reset = 1'b0;
      repeat (2) stepEdge();

      $display("[TB] test 2: clean step on channel 0");
      applyStimulus(4'b0001, 4'b0000);
      repeat (4) stepEdge();
      checkOutput("t2 cond edge4", conditioned, 4'b0000);
      checkOutput("t2 anypending edge4", anypending, 1'b0);
      stepEdge();
      checkOutput("t2 cond edge5", conditioned, 4'b0001);
      checkOutput("t2 posedge edge5", positiveedge, 4'b0001);
      checkOutput("t2 anypending edge5", anypending, 1'b1);
      stepEdge();
      checkOutput("t2 posedge edge6", positiveedge, 4'b0000);
      checkOutput("t2 anypending edge6", anypending, 1'b1);
      repeat (3) stepEdge();
      checkOutput("t2 pendingrise held", pendingrise, 4'b0001);
      checkOutput("t2 anypending held", anypending, 1'b1);
      applyStimulus(4'b0001, 4'b0001);
      stepEdge();
      applyStimulus(4'b0001, 4'b0000);
      checkOutput("t2 pendingrise cleared", pendingrise, 4'b0000);
      checkOutput("t2 anypending cleared", anypending, 1'b0);

      $display("[TB] test 3: glitch rejection on channel 1");
      applyStimulus(4'b0011, 4'b0000);
      stepEdge();
      checkOutput("t3 glitch1 ch1", {conditioned[1], positiveedge[1], pendingrise[1]}, 3'b000);
      applyStimulus(4'b0001, 4'b0000);
      for (int k = 0; k < 6; k++) begin
         stepEdge();
         checkOutput("t3 after glitch1 ch1", {conditioned[1], positiveedge[1], pendingrise[1]}, 3'b000);
      end
      applyStimulus(4'b0011, 4'b0000);
      for (int k = 0; k < 2; k++) begin
         stepEdge();
         checkOutput("t3 glitch2 ch1", {conditioned[1], positiveedge[1], pendingrise[1]}, 3'b000);
      end
      applyStimulus(4'b0001, 4'b0000);
      for (int k = 0; k < 6; k++) begin
         stepEdge();
         checkOutput("t3 after glitch2 ch1", {conditioned[1], positiveedge[1], pendingrise[1]}, 3'b000);
      end

      $display("[TB] test 4: falling edge with bounce on channel 2");
      applyStimulus(4'b0101, 4'b0000);
      repeat (5) stepEdge();
      checkOutput("t4 cond ch2 high", conditioned, 4'b0101);
      checkOutput("t4 posedge ch2", positiveedge, 4'b0100);
      applyStimulus(4'b0101, 4'b0100);
      stepEdge();
      checkOutput("t4 flags cleared", {pendingrise, pendingfall}, 8'h00);
      checkOutput("t4 anypending cleared", anypending, 1'b0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus((k % 2 == 0) ? 4'b0001 : 4'b0101, 4'b0000);
         stepEdge();
         checkOutput("t4 bounce ch2", {conditioned[2], negativeedge[2]}, 2'b10);
      end
      applyStimulus(4'b0001, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         stepEdge();
         checkOutput("t4 settling ch2", {conditioned[2], negativeedge[2]}, 2'b10);
      end
      stepEdge();
      checkOutput("t4 negedge edge5", negativeedge, 4'b0100);
      checkOutput("t4 cond edge5", conditioned, 4'b0001);
      checkOutput("t4 pendingfall", pendingfall, 4'b0100);
      checkOutput("t4 anypending", anypending, 1'b1);
      stepEdge();
      checkOutput("t4 negedge edge6", negativeedge, 4'b0000);

      $display("[TB] test 5: set and clear on the same edge, simultaneous channels");
      applyStimulus(4'b1001, 4'b0000);
      repeat (4) stepEdge();
      checkOutput("t5 cond ch3 edge4", conditioned[3], 1'b0);
      applyStimulus(4'b1001, 4'b1000);
      stepEdge();
      applyStimulus(4'b1001, 4'b0000);
      checkOutput("t5 cond ch3 edge5", conditioned, 4'b1001);
      checkOutput("t5 posedge ch3", positiveedge, 4'b1000);
      checkOutput("t5 pendingrise set wins", pendingrise, 4'b1000);
      stepEdge();
      checkOutput("t5 pendingrise held", pendingrise, 4'b1000);
      applyStimulus(4'b1010, 4'b0000);
      repeat (4) stepEdge();
      checkOutput("t5 pulses edge4", {positiveedge, negativeedge}, 8'h00);
      stepEdge();
      checkOutput("t5 posedge ch1", positiveedge, 4'b0010);
      checkOutput("t5 negedge ch0", negativeedge, 4'b0001);
      checkOutput("t5 cond both", conditioned, 4'b1010);

      $display("[TB] test 6: reset during a debounce count");
      applyStimulus(4'b1011, 4'b0000);
      repeat (4) stepEdge();
      checkOutput("t6 cond mid-count", conditioned, 4'b1010);
      reset = 1'b1;
      stepEdge();
      checkAllZero("t6 reset");
      reset = 1'b0;
      repeat (4) stepEdge();
      checkOutput("t6 cond edge4", conditioned, 4'b0000);
      checkOutput("t6 posedge edge4", positiveedge, 4'b0000);
      stepEdge();
      checkOutput("t6 cond edge5", conditioned, 4'b1011);
      checkOutput("t6 posedge edge5", positiveedge, 4'b1011);
      checkOutput("t6 pendingrise", pendingrise, 4'b1011);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
